// File: rtl/nonoverlap_clk_monitor.sv
// ---------------------------------------------------------------------------
// nonoverlap_clk_monitor
//
// Watches a set of non-overlapping clock phases (MOD, MODN, MODL) that are
// all synchronous to CLK_IN. It measures the following values in CLK_IN cycles:
//   - the MOD period
//   - the MOD high time
//   - the MOD-fall to MODN-rise gap
//   - the MOD-rise to MODL-rise offset
// A small FSM acquires lock once the waveform has shown LOCK_COUNT
// consecutive good periods. A sticky error flags phase overlap, and a
// second flag reports a MODL phase mismatch while locked.
//
// Parameters:
//   EXP_PERIOD  expected MOD rise-to-rise period
//   EXP_HIGH    expected MOD high time
//   MIN_GAP     minimum allowed MOD-fall to MODN-rise gap
//   LOCK_COUNT  consecutive good periods needed for lock
//
// Ports:
//   CLK_IN       single clock for the whole block
//   RESET        synchronous, active-high reset
//   MOD_IN       monitored phase
//   MODN_IN      monitored phase
//   MODL_IN      monitored phase
//   EXP_PHASE    expected MOD-rise to MODL-rise offset
//   PERIOD       last measured MOD period
//   MOD_HIGH     last measured MOD high time
//   GAP          last measured MOD-fall to MODN-rise gap
//   PHASE_MEAS   last measured MODL offset
//   MEAS_VALID   one-cycle pulse whenever PERIOD updates
//                (suppressed on the first MOD rise after reset)
//   LOCKED       high while the FSM sits in its locked state
//   OVERLAP_ERR  sticky non-overlap violation, cleared only by RESET
//   PHASE_ERR    MODL offset mismatch, only meaningful while locked
// ---------------------------------------------------------------------------
module nonoverlap_clk_monitor #(
  parameter int EXP_PERIOD = 32,
  parameter int EXP_HIGH   = 12,
  parameter int MIN_GAP    = 2,
  parameter int LOCK_COUNT = 2
) (
  input  logic       CLK_IN,
  input  logic       RESET,
  input  logic       MOD_IN,
  input  logic       MODN_IN,
  input  logic       MODL_IN,
  input  logic [5:0] EXP_PHASE,
  output logic [5:0] PERIOD,
  output logic [5:0] MOD_HIGH,
  output logic [5:0] GAP,
  output logic [5:0] PHASE_MEAS,
  output logic       MEAS_VALID,
  output logic       LOCKED,
  output logic       OVERLAP_ERR,
  output logic       PHASE_ERR
);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ACQ,
    ST_LOCKED,
    ST_FAULT
  } state_t;

  localparam logic [5:0] EXP_PERIOD_W = 6'(EXP_PERIOD);
  localparam logic [5:0] EXP_HIGH_W   = 6'(EXP_HIGH);
  localparam logic [5:0] MIN_GAP_W    = 6'(MIN_GAP);
  localparam logic [7:0] LOCK_TARGET  = 8'(LOCK_COUNT);
  localparam logic [5:0] CNT_MAX      = 6'd63;

  state_t     state;
  state_t     state_next;
  logic [7:0] good_cnt;
  logic [7:0] good_next;
  logic [5:0] cnt;

  logic       mod_prev;
  logic       modn_prev;
  logic       modl_prev;
  logic       phase_err_q;

  logic       mod_rise;
  logic       mod_fall;
  logic       modn_rise;
  logic       modl_rise;
  logic       period_good;
  logic [5:0] high_ref;
  logic [5:0] gap_new;
  logic [5:0] phase_new;

  // Edge detection against the previous sample of each phase.
  assign mod_rise  = MOD_IN & ~mod_prev;
  assign mod_fall  = ~MOD_IN & mod_prev;
  assign modn_rise = MODN_IN & ~modn_prev;
  assign modl_rise = MODL_IN & ~modl_prev;

  // A period is judged when the MOD rise that closes it arrives.
  // At that moment cnt holds the period just ended.
  // MOD_HIGH still holds the high time captured earlier in that period.
  assign period_good = (cnt == EXP_PERIOD_W) && (MOD_HIGH == EXP_HIGH_W);

  // A MOD fall and a MODN rise can land in the same cycle. In that case
  // the gap must be measured against the high time captured in this same
  // cycle, which makes the gap 0.
  assign high_ref  = mod_fall ? cnt : MOD_HIGH;
  assign gap_new   = cnt - high_ref;

  // A MODL rise that coincides with a MOD rise is at offset 0.
  // cnt still holds the old period at that point, so it is not used.
  assign phase_new = mod_rise ? 6'd0 : cnt;

  assign LOCKED    = (state == ST_LOCKED);
  assign PHASE_ERR = phase_err_q & (state == ST_LOCKED);

  // Next-state logic for the lock FSM and the good-period counter.
  always_comb begin
    state_next = state;
    good_next  = good_cnt;
    case (state)
      ST_IDLE: begin
        if (mod_rise) begin
          state_next = ST_ACQ;
          good_next  = 8'd0;
        end
      end
      ST_ACQ: begin
        if (mod_rise) begin
          if (period_good) begin
            good_next = good_cnt + 8'd1;
            if ((good_cnt + 8'd1) >= LOCK_TARGET) begin
              state_next = ST_LOCKED;
            end
          end else begin
            good_next = 8'd0;
          end
        end
      end
      ST_LOCKED: begin
        if ((mod_rise && !period_good) || (cnt == CNT_MAX)) begin
          state_next = ST_FAULT;
        end
      end
      ST_FAULT: begin
        if (mod_rise) begin
          state_next = ST_ACQ;
          good_next  = 8'd0;
        end
      end
      default: begin
        state_next = ST_IDLE;
        good_next  = 8'd0;
      end
    endcase
  end

  // State register and good-period counter.
  always_ff @(posedge CLK_IN) begin
    if (RESET) begin
      state    <= ST_IDLE;
      good_cnt <= 8'd0;
    end else begin
      state    <= state_next;
      good_cnt <= good_next;
    end
  end

  // Input history.
  // During reset the history tracks the live inputs, so a phase that is
  // already high at release is not mistaken for a rising edge.
  always_ff @(posedge CLK_IN) begin
    mod_prev  <= MOD_IN;
    modn_prev <= MODN_IN;
    modl_prev <= MODL_IN;
  end

  // Cycle counter.
  // It restarts at 1 right after each MOD rise, so its value at the next
  // rise is the full period. It saturates at 63 instead of wrapping, which
  // lets a stalled MOD be detected.
  always_ff @(posedge CLK_IN) begin
    if (RESET) begin
      cnt <= 6'd0;
    end else if (mod_rise) begin
      cnt <= 6'd1;
    end else if (cnt != CNT_MAX) begin
      cnt <= cnt + 6'd1;
    end
  end

  // Registered measurements and error flags.
  // Each measurement is taken from cnt on its own edge. The overlap flag
  // is sticky, so once set it is only cleared by reset.
  always_ff @(posedge CLK_IN) begin
    if (RESET) begin
      PERIOD      <= 6'd0;
      MOD_HIGH    <= 6'd0;
      GAP         <= 6'd0;
      PHASE_MEAS  <= 6'd0;
      MEAS_VALID  <= 1'b0;
      OVERLAP_ERR <= 1'b0;
      phase_err_q <= 1'b0;
    end else begin
      MEAS_VALID <= mod_rise && (state != ST_IDLE);
      if (mod_rise) begin
        PERIOD <= cnt;
      end
      if (mod_fall) begin
        MOD_HIGH <= cnt;
      end
      if (modn_rise) begin
        GAP <= gap_new;
      end
      if (modl_rise) begin
        PHASE_MEAS <= phase_new;
      end
      if ((MOD_IN && MODN_IN) || (modn_rise && (gap_new < MIN_GAP_W))) begin
        OVERLAP_ERR <= 1'b1;
      end
      if (state != ST_LOCKED) begin
        phase_err_q <= 1'b0;
      end else if (modl_rise) begin
        phase_err_q <= (phase_new != EXP_PHASE);
      end
    end
  end

endmodule

// File: tb/tb_nonoverlap_clk_monitor.sv
// ---------------------------------------------------------------------------
// tb_nonoverlap_clk_monitor
//
// Drives MOD/MODN/MODL waveforms period by period, covering these cases:
//   - nominal drive
//   - a stretched period
//   - a MODL phase mismatch
//   - a stalled MOD
//   - a mid-period reset
//   - a randomized segment
//   - overlap and zero-gap violations
//
// A reference model tracks when the last MOD rise happened and derives
// every output from elapsed-cycle arithmetic. The outputs are compared
// against the model after every clock edge. A few extra constant checks
// confirm the headline scenario results.
// ---------------------------------------------------------------------------
module tb_nonoverlap_clk_monitor;

  localparam int S_IDLE  = 0;
  localparam int S_ACQ   = 1;
  localparam int S_LOCK  = 2;
  localparam int S_FAULT = 3;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       modIn = 1'b0;
  logic       modnIn = 1'b0;
  logic       modlIn = 1'b0;
  logic [5:0] expPhase = 6'd5;
  logic [5:0] periodOut;
  logic [5:0] modHighOut;
  logic [5:0] gapOut;
  logic [5:0] phaseOut;
  logic       measValid;
  logic       lockedOut;
  logic       overlapErr;
  logic       phaseErr;

  int testsRun = 0;
  int testsFailed = 0;

  // Reference model state. The phase history holds the values that were
  // sampled at the previous clock edge.
  int mCycle, mLastRise, mState, mGood;
  int mPeriod, mHigh, mGap, mPhase;
  bit mValid, mOverlap, mPhaseRaw;
  bit pMod, pModn, pModl;

  always #5 clk = ~clk;

  nonoverlap_clk_monitor #(
    .EXP_PERIOD(32),
    .EXP_HIGH  (12),
    .MIN_GAP   (2),
    .LOCK_COUNT(2)
  ) dut (
    .CLK_IN     (clk),
    .RESET      (rst),
    .MOD_IN     (modIn),
    .MODN_IN    (modnIn),
    .MODL_IN    (modlIn),
    .EXP_PHASE  (expPhase),
    .PERIOD     (periodOut),
    .MOD_HIGH   (modHighOut),
    .GAP        (gapOut),
    .PHASE_MEAS (phaseOut),
    .MEAS_VALID (measValid),
    .LOCKED     (lockedOut),
    .OVERLAP_ERR(overlapErr),
    .PHASE_ERR  (phaseErr)
  );

  // Single comparison point. It counts the comparison and reports any
  // mismatch on one line.
  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    testsRun++;
    if (obs !== exp) begin
      testsFailed++;
      $display("[TB] FAIL %s: got %0d, expected %0d at %0t", tag, obs, exp, $time);
    end
  endtask

  // Advances the reference model by one clock edge, using the inputs that
  // were just driven.
  task automatic modelStep();
    int  e;
    int  newHigh;
    int  g;
    int  ph;
    int  oldState;
    bit  rM, fM, rN, rL, goodP;
    if (rst) begin
      mCycle = 0; mLastRise = 0; mState = S_IDLE; mGood = 0;
      mPeriod = 0; mHigh = 0; mGap = 0; mPhase = 0;
      mValid = 0; mOverlap = 0; mPhaseRaw = 0;
    end else begin
      e = mCycle - mLastRise;
      if (e > 63) e = 63;
      rM = modIn && !pMod;
      fM = !modIn && pMod;
      rN = modnIn && !pModn;
      rL = modlIn && !pModl;
      goodP = (e == 32) && (mHigh == 12);
      oldState = mState;
      ph = 0;

      mValid = rM && (oldState != S_IDLE);
      if (rM) mPeriod = e;
      newHigh = fM ? e : mHigh;
      mHigh = newHigh;
      if (rN) begin
        g = (e - newHigh) & 63;
        mGap = g;
        if (g < 2) mOverlap = 1;
      end
      if (modIn && modnIn) mOverlap = 1;
      if (rL) begin
        ph = rM ? 0 : e;
        mPhase = ph;
      end
      if (oldState != S_LOCK) mPhaseRaw = 0;
      else if (rL) mPhaseRaw = (ph != int'(expPhase));

      case (oldState)
        S_IDLE:  if (rM) begin mState = S_ACQ; mGood = 0; end
        S_ACQ: begin
          if (rM) begin
            if (goodP) begin
              mGood++;
              if (mGood >= 2) mState = S_LOCK;
            end else begin
              mGood = 0;
            end
          end
        end
        S_LOCK:  if ((rM && !goodP) || e == 63) mState = S_FAULT;
        default: if (rM) begin mState = S_ACQ; mGood = 0; end
      endcase

      if (rM) mLastRise = mCycle;
      mCycle++;
    end
    pMod = modIn;
    pModn = modnIn;
    pModl = modlIn;
  endtask

  // Drives one cycle of inputs on the falling edge and advances the model
  // at the rising edge. Every output is compared a moment later.
  task automatic applyStimulus(input logic m, input logic mn, input logic ml, input logic r);
    @(negedge clk);
    modIn = m;
    modnIn = mn;
    modlIn = ml;
    rst = r;
    @(posedge clk);
    modelStep();
    #1;
    checkOutput("period",     32'(periodOut),  32'(mPeriod));
    checkOutput("modHigh",    32'(modHighOut), 32'(mHigh));
    checkOutput("gap",        32'(gapOut),     32'(mGap));
    checkOutput("phaseMeas",  32'(phaseOut),   32'(mPhase));
    checkOutput("measValid",  32'(measValid),  32'(mValid));
    checkOutput("locked",     32'(lockedOut),  32'(mState == S_LOCK));
    checkOutput("overlapErr", 32'(overlapErr), 32'(mOverlap));
    checkOutput("phaseErr",   32'(phaseErr),   32'(mPhaseRaw && mState == S_LOCK));
  endtask

  // Drives one MOD period with these properties:
  //   - MOD is high for 12 cycles
  //   - MODN is high for 12 cycles from modnStart
  //   - MODL is high for 16 cycles from modlOff
  //   - reset is optionally asserted for two cycles starting at rstPos
  task automatic runPeriod(input int len, input int modnStart, input int modlOff, input int rstPos);
    for (int pos = 0; pos < len; pos++) begin
      applyStimulus(pos < 12,
                    (pos >= modnStart) && (pos < modnStart + 12),
                    (pos >= modlOff) && (pos < modlOff + 16),
                    (rstPos >= 0) && (pos >= rstPos) && (pos < rstPos + 2));
    end
  endtask

  task automatic resetBlock(input int cycles);
    for (int i = 0; i < cycles; i++) applyStimulus(1'b0, 1'b0, 1'b0, 1'b1);
  endtask

  initial begin
    pMod = 0; pModn = 0; pModl = 0;

    // Reset with arbitrary inputs, then settle every phase low.
    for (int i = 0; i < 2; i++) begin
      applyStimulus(1'($urandom), 1'($urandom), 1'($urandom), 1'b1);
    end
    resetBlock(1);
    checkOutput("resetLocked", 32'(lockedOut), 32'd0);
    checkOutput("resetPeriod", 32'(periodOut), 32'd0);

    // Nominal drive. Lock is reached on the third MOD rise.
    runPeriod(32, 16, 5, -1);
    runPeriod(32, 16, 5, -1);
    checkOutput("preLock", 32'(lockedOut), 32'd0);
    runPeriod(32, 16, 5, -1);
    runPeriod(32, 16, 5, -1);
    checkOutput("nomPeriod",  32'(periodOut),  32'd32);
    checkOutput("nomHigh",    32'(modHighOut), 32'd12);
    checkOutput("nomGap",     32'(gapOut),     32'd4);
    checkOutput("nomPhase",   32'(phaseOut),   32'd5);
    checkOutput("nomLocked",  32'(lockedOut),  32'd1);
    checkOutput("nomOverlap", 32'(overlapErr), 32'd0);
    checkOutput("nomPhErr",   32'(phaseErr),   32'd0);

    // One stretched period drops lock. Lock returns after two good periods.
    runPeriod(34, 16, 5, -1);
    runPeriod(32, 16, 5, -1);
    checkOutput("stretchFault", 32'(lockedOut), 32'd0);
    runPeriod(32, 16, 5, -1);
    runPeriod(32, 16, 5, -1);
    runPeriod(32, 16, 5, -1);
    checkOutput("stretchRelock", 32'(lockedOut), 32'd1);

    // Expected MODL offset is wrong while locked.
    expPhase = 6'd7;
    runPeriod(32, 16, 5, -1);
    checkOutput("phaseMismatch", 32'(phaseErr), 32'd1);
    expPhase = 6'd5;
    runPeriod(32, 16, 5, -1);
    checkOutput("phaseRestored", 32'(phaseErr), 32'd0);

    // A stalled MOD stays low long enough for the counter to saturate.
    runPeriod(82, 16, 5, -1);
    checkOutput("stallFault", 32'(lockedOut), 32'd0);
    runPeriod(32, 16, 5, -1);
    checkOutput("stallPeriod", 32'(periodOut), 32'd63);
    runPeriod(32, 16, 5, -1);
    runPeriod(32, 16, 5, -1);
    runPeriod(32, 16, 5, -1);
    checkOutput("stallRelock", 32'(lockedOut), 32'd1);

    // Reset mid-period while MOD is high at release.
    runPeriod(32, 16, 5, 3);
    checkOutput("midRstLocked", 32'(lockedOut), 32'd0);
    for (int i = 0; i < 4; i++) runPeriod(32, 16, 5, -1);
    checkOutput("midRstRelock", 32'(lockedOut), 32'd1);

    // Randomized periods, MODN gaps, MODL offsets and expected offsets.
    for (int i = 0; i < 20; i++) begin
      expPhase = 6'($urandom_range(0, 10));
      runPeriod(int'($urandom_range(30, 36)), int'($urandom_range(14, 17)),
                int'($urandom_range(0, 10)), -1);
    end

    // Zero gap case: the fall of MOD and the rise of MODN share a cycle.
    expPhase = 6'd5;
    runPeriod(32, 12, 5, -1);
    checkOutput("zeroGap", 32'(gapOut), 32'd0);
    checkOutput("zeroGapErr", 32'(overlapErr), 32'd1);
    resetBlock(2);
    checkOutput("zeroGapCleared", 32'(overlapErr), 32'd0);

    // Early MODN rise by one cycle overlaps MOD. The error is sticky.
    for (int i = 0; i < 3; i++) runPeriod(32, 16, 5, -1);
    runPeriod(32, 11, 5, -1);
    checkOutput("overlapSet", 32'(overlapErr), 32'd1);
    runPeriod(32, 16, 5, -1);
    runPeriod(32, 16, 5, -1);
    checkOutput("overlapSticky", 32'(overlapErr), 32'd1);
    resetBlock(2);
    checkOutput("overlapCleared", 32'(overlapErr), 32'd0);
    checkOutput("finalLocked", 32'(lockedOut), 32'd0);

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
